sys_run_ctrl: RTL
=================

# sys_run_ctrl

Parametrised run-control and debug-observation block for the MIPS system top. It sits between the board inputs (mode switches, step button, output selector) and the CPU core. It generates the core's clock-enable from a programmable divisor and adds single-step, halt and PC-breakpoint modes. It also drives the LED bank from one of NUM_CH debug channels. It replaces the fixed divider/selector logic in `system`, and the system testbench drives it through the same `clk`/`SYS_output_sel` style ports.

## Interface
- DIVISOR, 1: clk cycles per CPU enable tick; legal values are 1 and above.
- NUM_CH, 8: number of debug channels.
- SEL_W, 3: width of SYS_output_sel; must satisfy 2^SEL_W ≥ NUM_CH.
- DATA_W, 32: width of each debug channel.
- LED_W, 27: LED bank width; must satisfy LED_W ≤ DATA_W.
- PC_W, 8: width of the observed PC.
- clk  in  1  system clock; all logic is in this single domain.
- SYS_reset_n  in  1  asynchronous, active-low reset.
- SYS_mode  in  2  operating mode: 00 RUN, 01 STEP, 10 BREAK, 11 HALT.
- SYS_step  in  1  raw step/resume button, asynchronous level.
- SYS_bp_addr  in  PC_W  breakpoint PC.
- SYS_output_sel  in  SEL_W  debug channel select.
- cpu_pc  in  PC_W  current PC of the core.
- dbg_data  in  NUM_CH*DATA_W  packed debug channels; channel k occupies bits [k*DATA_W +: DATA_W].
- cpu_ce  out  1  one-clk CPU advance pulse.
- CLK_led  out  1  toggles on every cpu_ce.
- SYS_leds  out  LED_W  registered selected channel.
- halted  out  1  high while the state is HALT.
- cycle_count  out  32  number of cpu_ce pulses issued; saturates at all-ones.

## Operation
- Reset values:
  - All outputs are 0.
  - State is RUN, div_cnt is 0, step_pending is 0, skip_bp is 0.
- Tick generation:
  - div_cnt counts 0 to DIVISOR-1 and wraps.
  - tick is asserted when div_cnt equals DIVISOR-1.
  - With DIVISOR=1, tick is asserted every cycle.
- Step input:
  - SYS_step passes through a 2-flop synchronizer followed by a rising-edge detector, giving step_edge.
  - step_edge sets step_pending.
  - step_edge while step_pending is already set is ignored; presses are not counted.
- RUN state:
  - cpu_ce = tick.
  - SYS_mode=HALT moves to HALT. SYS_mode=STEP moves to STEP.
  - In BREAK mode, when tick is high, cpu_pc equals SYS_bp_addr and skip_bp is 0: no cpu_ce is issued and the state moves to HALT.
  - skip_bp clears on the first cpu_ce after it was set.
- STEP state:
  - cpu_ce = tick AND step_pending. The grant clears step_pending.
  - If a grant and a step_edge occur in the same cycle, the edge wins and step_pending stays set.
  - SYS_mode=RUN or BREAK moves to RUN. SYS_mode=HALT moves to HALT.
- HALT state:
  - cpu_ce is 0 and halted is 1.
  - SYS_mode=RUN moves to RUN. SYS_mode=STEP moves to STEP.
  - With SYS_mode=BREAK, a step_edge moves to RUN and sets skip_bp, so the halted PC executes once before the breakpoint can re-trigger.
  - With SYS_mode=HALT, the state is held.
- LED path:
  - SYS_leds <= low LED_W bits of the selected channel, registered every clk, independent of state.
  - A select value ≥ NUM_CH gives 0.
- Counters: cycle_count increments on each cpu_ce and saturates at all-ones.

## Timing
- First cpu_ce occurs in the DIVISOR-th clk after reset release.
- cpu_ce, CLK_led, cycle_count and halted are registered and change on the same edge.
- Mode changes take effect on the next clk edge. An in-flight tick is not lost: div_cnt runs in every state.
- Step latency: button to step_edge is 3 clk. step_edge to cpu_ce is 1 to DIVISOR clk, depending on the next tick.
- SYS_leds latency: 1 clk from SYS_output_sel or dbg_data.
- Reset asserted mid-operation clears every register immediately, without waiting for a clock. The first tick after release follows the reset-release timing above.

## Structure
- Shared package `sys_defs`:
  - mode encodings MODE_RUN/STEP/BREAK/HALT;
  - state encodings ST_RUN/ST_STEP/ST_HALT;
  - default widths.
- Sub-module `sys_clk_div`: parametrised tick generator holding div_cnt. It is reused for other divided enables.
- The remaining logic is the top file: synchronizer, FSM, counters and LED mux.

## Test plan
- DIVISOR=4, RUN, reset released at t0 -> cpu_ce at clk 4, 8 and 12; CLK_led reads 1, 0, 1; cycle_count=3.
- STEP, DIVISOR=2 -> two separated presses give exactly two cpu_ce pulses; a press while pending adds none; cycle_count=2.
- BREAK, bp=0x10, bench PC += 4 per cpu_ce starting at 0 -> cpu_ce at PC 0, 4, 8 and 0xC; then halted=1 at PC 0x10 with no cpu_ce; a step press resumes with cpu_ce at 0x10 and halted=0.
- NUM_CH=8, channel 3=0xDEADBEEF, sel=3 -> SYS_leds=0x6ADBEEF one clk later. With NUM_CH=6 and sel=7 -> SYS_leds=0.
- SYS_reset_n pulled low between edges during RUN -> all outputs 0 before the next edge; after release, first cpu_ce follows DIVISOR.
- cycle_count preloaded via force to 0xFFFFFFFE, run 3 ticks -> cycle_count holds 0xFFFFFFFF.

Source files
------------

// File: rtl/sys_run_ctrl_pkg.sv
// Shared encodings and default widths for the run-control block and its helpers.
package sys_defs;

  localparam int DEF_DIVISOR = 1;
  localparam int DEF_NUM_CH  = 8;
  localparam int DEF_SEL_W   = 3;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_LED_W   = 27;
  localparam int DEF_PC_W    = 8;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'b00,
    MODE_STEP  = 2'b01,
    MODE_BREAK = 2'b10,
    MODE_HALT  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_STEP = 2'b01,
    ST_HALT = 2'b10
  } state_e;

endpackage

// File: rtl/sys_run_ctrl_clk_div.sv
// Free-running divider: o_tick is high for one clk out of every DIVISOR clks.
module sys_clk_div #(
  parameter int DIVISOR = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] r_div_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == LAST) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + CNT_W'(1);
    end
  end

  assign o_tick = (r_div_cnt == LAST);

endmodule

// File: rtl/sys_run_ctrl.sv
// CPU run control (run/step/break/halt clock-enable) and LED debug-channel mux.
module sys_run_ctrl
  import sys_defs::*;
#(
  parameter int DIVISOR = DEF_DIVISOR,
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LED_W   = DEF_LED_W,
  parameter int PC_W    = DEF_PC_W
) (
  input  logic                     clk,
  input  logic                     SYS_reset_n,
  input  logic [1:0]               SYS_mode,
  input  logic                     SYS_step,
  input  logic [PC_W-1:0]          SYS_bp_addr,
  input  logic [SEL_W-1:0]         SYS_output_sel,
  input  logic [PC_W-1:0]          cpu_pc,
  input  logic [NUM_CH*DATA_W-1:0] dbg_data,
  output logic                     cpu_ce,
  output logic                     CLK_led,
  output logic [LED_W-1:0]         SYS_leds,
  output logic                     halted,
  output logic [31:0]              cycle_count
);

  state_e           r_state, w_state_nxt;
  mode_e            w_mode;
  logic             w_tick;
  logic [1:0]       r_step_sync;
  logic             r_step_prev;
  logic             w_step_edge;
  logic             r_step_pending;
  logic             r_skip_bp;
  logic             w_grant, w_ce_nxt, w_skip_set;
  logic             r_cpu_ce, r_clk_led, r_halted;
  logic [31:0]      r_cycle_count;
  logic [LED_W-1:0] r_leds, w_led_nxt;
  logic             w_unused_dbg;

  sys_clk_div #(.DIVISOR(DIVISOR)) u_clk_div (
    .i_clk   (clk),
    .i_rst_n (SYS_reset_n),
    .o_tick  (w_tick)
  );

  assign w_mode      = mode_e'(SYS_mode);
  assign w_step_edge = r_step_sync[1] & ~r_step_prev;

  always_comb begin
    w_state_nxt = r_state;
    w_ce_nxt    = 1'b0;
    w_grant     = 1'b0;
    w_skip_set  = 1'b0;
    case (r_state)
      ST_RUN: begin
        // A breakpoint hit swallows the tick so the core stops before executing bp_addr.
        if (w_mode == MODE_BREAK && w_tick && cpu_pc == SYS_bp_addr && !r_skip_bp) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_ce_nxt = w_tick;
          if (w_mode == MODE_HALT)      w_state_nxt = ST_HALT;
          else if (w_mode == MODE_STEP) w_state_nxt = ST_STEP;
        end
      end
      ST_STEP: begin
        w_grant  = w_tick & r_step_pending;
        w_ce_nxt = w_grant;
        if (w_mode == MODE_RUN || w_mode == MODE_BREAK) w_state_nxt = ST_RUN;
        else if (w_mode == MODE_HALT)                   w_state_nxt = ST_HALT;
      end
      ST_HALT: begin
        if (w_mode == MODE_RUN)       w_state_nxt = ST_RUN;
        else if (w_mode == MODE_STEP) w_state_nxt = ST_STEP;
        else if (w_mode == MODE_BREAK && w_step_edge) begin
          w_state_nxt = ST_RUN;
          w_skip_set  = 1'b1;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      r_state        <= ST_RUN;
      r_step_sync    <= '0;
      r_step_prev    <= 1'b0;
      r_step_pending <= 1'b0;
      r_skip_bp      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_step_sync <= {r_step_sync[0], SYS_step};
      r_step_prev <= r_step_sync[1];
      // A new press landing on the grant cycle keeps the request alive.
      if (w_step_edge)  r_step_pending <= 1'b1;
      else if (w_grant) r_step_pending <= 1'b0;
      if (w_skip_set)    r_skip_bp <= 1'b1;
      else if (w_ce_nxt) r_skip_bp <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      r_cpu_ce      <= 1'b0;
      r_clk_led     <= 1'b0;
      r_halted      <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_cpu_ce <= w_ce_nxt;
      r_halted <= (w_state_nxt == ST_HALT);
      if (w_ce_nxt) begin
        r_clk_led <= ~r_clk_led;
        if (r_cycle_count != '1) r_cycle_count <= r_cycle_count + 32'd1;
      end
    end
  end

  always_comb begin
    w_led_nxt = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (SYS_output_sel == SEL_W'(k)) w_led_nxt = dbg_data[k*DATA_W +: LED_W];
    end
  end

  always_ff @(posedge clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) r_leds <= '0;
    else              r_leds <= w_led_nxt;
  end

  assign w_unused_dbg = ^dbg_data;

  assign cpu_ce      = r_cpu_ce;
  assign CLK_led     = r_clk_led;
  assign SYS_leds    = r_leds;
  assign halted      = r_halted;
  assign cycle_count = r_cycle_count;

endmodule
